// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment display controllers.
package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    typedef logic [3:0] digit_t;
    typedef logic [6:0] seg_t;

    localparam seg_t                  SEG_OFF = 7'h7F;
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = 4'hF;

    typedef struct packed {
        logic [NUM_DIGITS*4-1:0] value;
        logic [NUM_DIGITS-1:0]   dp;
        logic [NUM_DIGITS-1:0]   blank;
    } display_word_t;

    // A freshly reset display is fully dark until the first commit.
    localparam display_word_t DISPLAY_RESET = '{value: 16'h0000, dp: 4'h0, blank: 4'hF};

endpackage

// File: rtl/seg7_hex.sv
// Combinational hex digit to active-low segment encoder, bit order {g,f,e,d,c,b,a}.
module seg7_hex
    import seg7_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // Lookup of the active-low pattern for each hex value.
    always_comb begin
        seg = SEG_OFF;
        case (digit)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            4'hF:    seg = 7'h0E;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/digit_scan_ctrl.sv
// Four-digit common-anode scan controller with frame-synchronous shadow commit
// and a per-slot anti-ghosting guard interval.
module digit_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int PRESCALE = 100000,
    parameter int GUARD    = 4,
    parameter int CNT_W    = 17
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank,
    output logic [1:0]  sel,
    output logic [3:0]  an_n,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic        ack,
    output logic        frame_done
);

    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] GUARD_C = CNT_W'(GUARD);

    logic [CNT_W-1:0] cnt_r;
    logic [1:0]       sel_r;
    logic             pending_r;
    display_word_t    shadow_r;
    display_word_t    disp_r;
    logic [3:0]       an_n_r;
    logic [6:0]       seg_n_r;
    logic             dp_n_r;
    logic             ack_r;
    logic             frame_done_r;

    logic             slot_end_s;
    logic             frame_end_s;
    logic             show_s;
    logic [3:0]       digit_s;
    logic [6:0]       seg_s;
    logic [3:0]       an_nxt_s;
    logic [6:0]       seg_nxt_s;
    logic             dp_nxt_s;

    assign slot_end_s  = en && (cnt_r == LAST_C);
    assign frame_end_s = slot_end_s && (sel_r == 2'd3);
    assign digit_s     = disp_r.value[{sel_r, 2'b00} +: 4];

    seg7_hex u_hex (
        .digit (digit_s),
        .seg   (seg_s)
    );

    // Slot prescaler and digit index; both freeze while scanning is disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
            sel_r <= 2'd0;
        end else if (slot_end_s) begin
            cnt_r <= '0;
            sel_r <= sel_r + 2'd1;
        end else if (en) begin
            cnt_r <= cnt_r + CNT_W'(1);
            sel_r <= sel_r;
        end else begin
            cnt_r <= cnt_r;
            sel_r <= sel_r;
        end
    end

    // Shadow capture and frame-boundary commit; the commit reads the old
    // shadow so a load landing on the boundary waits for the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_r     <= DISPLAY_RESET;
            disp_r       <= DISPLAY_RESET;
            pending_r    <= 1'b0;
            ack_r        <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= frame_end_s;
            ack_r        <= frame_end_s && pending_r;
            if (frame_end_s && pending_r) begin
                disp_r <= shadow_r;
            end else begin
                disp_r <= disp_r;
            end
            if (load) begin
                shadow_r  <= '{value: value, dp: dp_in, blank: blank};
                pending_r <= 1'b1;
            end else if (frame_end_s) begin
                shadow_r  <= shadow_r;
                pending_r <= 1'b0;
            end else begin
                shadow_r  <= shadow_r;
                pending_r <= pending_r;
            end
        end
    end

    // Next display drive: dark during the guard interval, when disabled, or when blanked.
    always_comb begin
        show_s    = en && (cnt_r >= GUARD_C) && !disp_r.blank[sel_r];
        an_nxt_s  = AN_OFF;
        seg_nxt_s = SEG_OFF;
        dp_nxt_s  = 1'b1;
        if (show_s) begin
            an_nxt_s  = ~(4'b0001 << sel_r);
            seg_nxt_s = seg_s;
            dp_nxt_s  = ~disp_r.dp[sel_r];
        end else begin
            an_nxt_s  = AN_OFF;
            seg_nxt_s = SEG_OFF;
            dp_nxt_s  = 1'b1;
        end
    end

    // Registered display outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_n_r  <= AN_OFF;
            seg_n_r <= SEG_OFF;
            dp_n_r  <= 1'b1;
        end else begin
            an_n_r  <= an_nxt_s;
            seg_n_r <= seg_nxt_s;
            dp_n_r  <= dp_nxt_s;
        end
    end

    assign sel        = sel_r;
    assign an_n       = an_n_r;
    assign seg_n      = seg_n_r;
    assign dp_n       = dp_n_r;
    assign ack        = ack_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Directed bench for digit_scan_ctrl with a short prescale (4 cycles/slot, 1 guard cycle).
module tb_digit_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = 16'h0000;
    logic [3:0]  dp_in = 4'h0;
    logic [3:0]  blank = 4'h0;
    logic [1:0]  sel;
    logic [3:0]  an_n;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic        ack;
    logic        frame_done;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int ack_win = 0;
    int a_seen  = 0;
    int ack_rst = 0;
    int lit_rst = 0;

    digit_scan_ctrl #(.PRESCALE(4), .GUARD(1), .CNT_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load       (load),
        .value      (value),
        .dp_in      (dp_in),
        .blank      (blank),
        .sel        (sel),
        .an_n       (an_n),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .ack        (ack),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h want %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_dark(input string tag);
        check_val({tag, "_an"}, 16'(an_n), 16'hF);
        check_val({tag, "_seg"}, 16'(seg_n), 16'h7F);
        check_val({tag, "_dp"}, 16'(dp_n), 16'h1);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_dark("rst");
        check_val("rst_sel", 16'(sel), 16'h0);
        check_val("rst_ack", 16'(ack), 16'h0);
        check_val("rst_fd", 16'(frame_done), 16'h0);
        rst_n = 1'b1;
        en    = 1'b1;
        cyc   = 0;

        while (cyc < 172) begin
            step();
            load = 1'b0;
            if (cyc >= 49 && cyc <= 78) begin
                if (ack) ack_win++;
                if (seg_n == 7'h08) a_seen++;
            end
            if (cyc >= 122 && cyc <= 131) begin
                check_dark("gap");
                check_val("gap_sel", 16'(sel), 16'h2);
                check_val("gap_fd", 16'(frame_done), 16'h0);
            end
            case (cyc)
                1:   check_val("sel_s0", 16'(sel), 16'h0);
                4:   check_val("sel_s1", 16'(sel), 16'h1);
                6:   check_val("blank_an", 16'(an_n), 16'hF);
                8:   check_val("sel_s2", 16'(sel), 16'h2);
                12:  check_val("sel_s3", 16'(sel), 16'h3);
                15:  check_val("fd_pre", 16'(frame_done), 16'h0);
                16: begin
                    check_val("fd_pulse", 16'(frame_done), 16'h1);
                    check_val("sel_wrap", 16'(sel), 16'h0);
                end
                17:  check_val("fd_post", 16'(frame_done), 16'h0);
                21: begin
                    load = 1'b1; value = 16'h1234; dp_in = 4'b0001; blank = 4'b0000;
                end
                31:  check_val("ack_pre", 16'(ack), 16'h0);
                32:  check_val("ack_1234", 16'(ack), 16'h1);
                33: begin
                    check_val("ack_post", 16'(ack), 16'h0);
                    check_val("guard0_an", 16'(an_n), 16'hF);
                end
                34: begin
                    check_val("d0_an", 16'(an_n), 16'hE);
                    check_val("d0_seg", 16'(seg_n), 16'h19);
                    check_val("d0_dp", 16'(dp_n), 16'h0);
                end
                38: begin
                    check_val("d1_an", 16'(an_n), 16'hD);
                    check_val("d1_seg", 16'(seg_n), 16'h30);
                    check_val("d1_dp", 16'(dp_n), 16'h1);
                end
                45:  check_val("guard3_an", 16'(an_n), 16'hF);
                46: begin
                    check_val("d3_an", 16'(an_n), 16'h7);
                    check_val("d3_seg", 16'(seg_n), 16'h79);
                end
                49: begin
                    load = 1'b1; value = 16'hAAAA; dp_in = 4'b0000;
                end
                53:  begin
                    load = 1'b1; value = 16'hBEEF;
                end
                66: begin
                    check_val("beef0_an", 16'(an_n), 16'hE);
                    check_val("beef0_seg", 16'(seg_n), 16'h0E);
                    check_val("beef0_dp", 16'(dp_n), 16'h1);
                end
                78: begin
                    check_val("beef3_an", 16'(an_n), 16'h7);
                    check_val("beef3_seg", 16'(seg_n), 16'h03);
                    check_val("ack_single", 16'(ack_win), 16'h1);
                    check_val("aaaa_never", 16'(a_seen), 16'h0);
                    load = 1'b1; value = 16'h5678;
                end
                79:  begin
                    load = 1'b1; value = 16'h9ABC;
                end
                80:  check_val("ack_coinc1", 16'(ack), 16'h1);
                81:  check_val("ack_coinc_post", 16'(ack), 16'h0);
                82: begin
                    check_val("c5678_an", 16'(an_n), 16'hE);
                    check_val("c5678_seg", 16'(seg_n), 16'h00);
                end
                96:  check_val("ack_coinc2", 16'(ack), 16'h1);
                98:  check_val("c9abc_seg", 16'(seg_n), 16'h46);
                121: en = 1'b0;
                131: en = 1'b1;
                133: begin
                    check_val("resume_sel", 16'(sel), 16'h2);
                    check_val("resume_an", 16'(an_n), 16'hB);
                    check_val("resume_seg", 16'(seg_n), 16'h08);
                end
                134: check_val("resume_s3", 16'(sel), 16'h3);
                138: begin
                    check_val("resume_fd", 16'(frame_done), 16'h1);
                    check_val("resume_wrap", 16'(sel), 16'h0);
                end
                139: begin
                    load = 1'b1; value = 16'h0007; blank = 4'b1000;
                end
                154: check_val("ack_blank", 16'(ack), 16'h1);
                156: begin
                    check_val("b7_an", 16'(an_n), 16'hE);
                    check_val("b7_seg", 16'(seg_n), 16'h78);
                end
                159: check_val("guard1_an", 16'(an_n), 16'hF);
                160: begin
                    check_val("b0_an", 16'(an_n), 16'hD);
                    check_val("b0_seg", 16'(seg_n), 16'h40);
                end
                164: check_val("b2_an", 16'(an_n), 16'hB);
                168: check_dark("blank3a");
                169: check_dark("blank3b");
                171: begin
                    load = 1'b1; value = 16'h1111; blank = 4'b0000;
                end
                172: begin
                    check_val("pre_rst_an", 16'(an_n), 16'hE);
                    check_val("pre_rst_seg", 16'(seg_n), 16'h78);
                end
                default: ;
            endcase
        end

        // Mid-slot async reset: outputs clear without waiting for a clock edge.
        #2 rst_n = 1'b0;
        #1;
        check_dark("async_rst");
        check_val("async_rst_sel", 16'(sel), 16'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 24; i++) begin
            step();
            if (ack) ack_rst++;
            if (an_n != 4'hF) lit_rst++;
        end
        check_val("rst_pending_lost", 16'(ack_rst), 16'h0);
        check_val("rst_display_dark", 16'(lit_rst), 16'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/digit_scan_ctrl.md
Name: digit_scan_ctrl

Overview:
- Time-multiplexed scan controller for a 4-digit common-anode seven-segment display.
- Steps a 2-bit digit index through 0..3 at a programmable slot rate and decodes it to active-low anode enables.
- Drives the hex-encoded segment pattern for the selected digit.
- Buffers new display values in a shadow register and commits them only at frame boundaries, so a frame never shows a mix of old and new digits.

Parameters:
- PRESCALE, 100000: clock cycles per digit slot; must be >= 2.
- GUARD, 4: cycles at the start of each slot with all anodes off (anti-ghosting); must be < PRESCALE.
- CNT_W, 17: prescaler width; must satisfy 2^CNT_W >= PRESCALE.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  scan enable
- load  in  1  one-cycle request to capture value/dp_in/blank
- value  in  16  four hex digits; digit k = value[4k+3:4k]
- dp_in  in  4  decimal point per digit, 1 = lit
- blank  in  4  per-digit blank, 1 = digit dark
- sel  out  2  current digit index
- an_n  out  4  anode enables, active-low, one-hot-cold
- seg_n  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp_n  out  1  decimal point, active-low
- ack  out  1  one-cycle pulse when pending data is committed
- frame_done  out  1  one-cycle pulse at end of slot 3

Behaviour:
- Reset (async assert, sync release):
  - sel=0, prescaler=0, pending=0.
  - Shadow and display registers = 0; display blank = 4'hF.
  - an_n=4'hF, seg_n=7'h7F, dp_n=1, ack=0, frame_done=0.
- Prescaler:
  - When en=1, counts 0..PRESCALE-1 and wraps to 0.
  - Slot end = counter at PRESCALE-1 with en=1.
  - At slot end, sel <= sel+1 mod 4 (3 wraps to 0).
- Frame boundary = slot end with sel==3.
  - frame_done pulses in the following cycle.
- Load:
  - load=1 in any cycle copies value/dp_in/blank into the shadow register and sets pending.
  - This applies regardless of en.
  - A load while pending is already set overwrites the shadow (last write wins); only one ack follows.
- Commit:
  - At a frame boundary with pending=1: shadow -> display register, pending cleared, ack=1 in the next cycle.
  - Simultaneous load and frame boundary: the shadow is committed first. The new load is captured into the shadow and pending stays 1 for the next frame.
- Outputs, registered and one cycle after sel/counter:
  - Counter < GUARD, or display blank[sel]=1: an_n=4'hF, seg_n=7'h7F, dp_n=1.
  - Otherwise: an_n = ~(1<<sel), seg_n = hex pattern of display digit[sel], dp_n = ~dp[sel].
- Hex patterns (a..g active-low, bit0=a):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- en=0:
  - Prescaler and sel hold.
  - an_n=4'hF, seg_n=7'h7F, dp_n=1 from the next cycle.
  - No commits, and frame_done stays 0.
  - On en rising, resume from the held counter.
- Reset mid-frame: all state returns to reset values immediately; pending data is lost.

Decomposition:
- Shared package seg7_pkg holds:
  - NUM_DIGITS=4 and typedef digit_t (logic [3:0]).
  - typedef seg_t (logic [6:0]) and constants SEG_OFF=7'h7F, AN_OFF=4'hF.
  - A display_word_t struct {value, dp, blank}.
- One sub-module: seg7_hex, a combinational digit_t -> seg_t encoder using the table above.
- The one-hot anode decode stays inline.

Test Plan:
- Reset, then en=1 with PRESCALE=4, GUARD=1 -> all outputs at reset values; sel sequence 0,1,2,3,0 changing every 4 cycles; frame_done pulses once per 16 cycles.
- load value=16'h1234, dp_in=4'b0001, blank=0 during slot 1 -> ack exactly 1 cycle after the next sel 3->0 transition.
  - Slot 0 then shows an_n=1110, seg_n=19 ("4"), dp_n=0.
  - Slot 3 shows an_n=0111, seg_n=79 ("1").
- Two loads (16'hAAAA then 16'hBEEF) inside one frame -> single ack; display shows BEEF; AAAA never appears.
- load coinciding with the frame boundary cycle -> old shadow commits with ack; the new value commits at the next boundary with a second ack.
- en dropped mid-slot 2 for 10 cycles -> an_n=F and seg_n=7F during the gap; sel stays 2; slot 2 completes its remaining count after en returns.
- blank=4'b1000 and value=16'h0007 -> slot 3 stays dark (an_n=F); guard cycle at every slot start has an_n=F; assert rst_n low mid-slot -> outputs return to reset values immediately.
